// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//
// Multi-cycle WIDTH-bit subtractor: D = A - B - borrow_in, processed 4 bits per clock
// with a single registered carry between nibbles. Subtraction is done as
// A + ~B + carry, where carry = ~borrow, so the nibble chain is a plain adder.
//
// Sequence: IDLE --start--> RUN (N = WIDTH/4 cycles) --> DONE (1 cycle) --> IDLE.
// The result and flags are registered at the last RUN edge and held until the next
// operation completes or Reset is asserted.
//
// Ports:
//   Clk         system clock, rising-edge active
//   Reset       asynchronous, active-high reset
//   start       operation request, sampled only in IDLE
//   A, B        minuend / subtrahend, latched on accepted start
//   borrow_in   borrow into bit 0, latched on accepted start
//   busy        high while the FSM is in RUN
//   done        one-cycle pulse while the FSM is in DONE (result just updated)
//   D           difference, mod 2^WIDTH
//   borrow_out  borrow out of the MSB (unsigned A < B + borrow_in)
//   overflow    signed two's-complement overflow
//   zero        D == 0

module nibble_serial_subtractor #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             carry_q;
   logic [CW-1:0]    count_q;

   logic [3:0]       a_nib, b_nib;
   logic [4:0]       nib_sum;
   logic             last_nib;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (last_nib) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // Unconditional return; a start seen here is dropped, not queued.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (decoded from state so Reset clears them immediately)
   // ------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StIdle:  ;
         StRun:   busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Nibble datapath
   // ------------------------------------------------------------------
   always_comb begin
      a_nib  = '0;
      b_nib  = '0;
      diff_d = diff_q;

      // Select the nibble addressed by count_q (constant slices only).
      for (int i = 0; i < int'(N); i++) begin
         if (count_q == CW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end

      // A - B - borrow == A + ~B + (1 - borrow); nib_sum[4] is the next carry.
      nib_sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};

      for (int i = 0; i < int'(N); i++) begin
         if (count_q == CW'(i)) begin
            diff_d[4*i +: 4] = nib_sum[3:0];
         end
      end

      last_nib = (count_q == CW'(N - 1));
   end

   // ------------------------------------------------------------------
   // Operand, progress and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         a_q        <= '0;
         b_q        <= '0;
         diff_q     <= '0;
         carry_q    <= 1'b0;
         count_q    <= '0;
         D          <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= ~borrow_in;
                  count_q <= '0;
               end
            end
            StRun: begin
               diff_q  <= diff_d;
               carry_q <= nib_sum[4];
               count_q <= count_q + CW'(1);
               if (last_nib) begin
                  D          <= diff_d;
                  borrow_out <= ~nib_sum[4];
                  // Operands of differing sign whose result sign differs from A.
                  overflow   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                  zero       <= (diff_d == '0);
               end
            end
            StDone:  ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH = 16).
// A cycle-level model decides which starts are accepted and when busy/done are due;
// results come from plain integer arithmetic and are checked by a separate monitor.

module tb_nibble_serial_subtractor;

   localparam int unsigned WIDTH = 16;
   localparam int N = WIDTH / 4;

   logic             Clk;
   logic             Reset;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             borrow_out;
   logic             overflow;
   logic             zero;

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (start),
      .A          (A),
      .B          (B),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .D          (D),
      .borrow_out (borrow_out),
      .overflow   (overflow),
      .zero       (zero)
   );

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bo;
      logic             ov;
      logic             z;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc   = -100;  // cycle index of the most recent accepted start
   int   free_at = 0;   // first cycle at which a new start can be accepted
   exp_t exp_q[$];
   exp_t held = '0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Reference: integer subtraction, unsigned and signed views.
   function automatic exp_t ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic bin);
      exp_t r;
      int   ua, ub, ud, sa, sb, sd;
      ua   = int'(a);
      ub   = int'(b);
      ud   = ua - ub - int'(bin);
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      sd   = sa - sb - int'(bin);
      r.d  = ud[WIDTH-1:0];
      r.bo = (ud < 0);
      r.ov = (sd < -32768) || (sd > 32767);
      r.z  = (r.d == '0);
      return r;
   endfunction

   // Model: acceptance timing and expected results (pushed at the accepting edge).
   initial begin
      forever begin
         @(posedge Clk);
         cyc++;
         if (Reset) begin
            exp_q.delete();
            acc     = -100;
            free_at = 0;
         end else if (start && cyc >= free_at) begin
            exp_q.push_back(ref_sub(A, B, borrow_in));
            acc     = cyc;
            free_at = cyc + N + 2;
         end
      end
   end

   // Monitor: sample 1 time unit after each rising edge.
   initial begin
      logic bexp, dexp;
      forever begin
         @(posedge Clk);
         #1;
         if (Reset) begin
            held = '0;
         end else begin
            bexp = (acc >= 0) && (cyc >= acc) && (cyc < acc + N);
            dexp = (acc >= 0) && (cyc == acc + N);
            chk("busy", 32'(busy), 32'(bexp));
            chk("done", 32'(done), 32'(dexp));
            if (done) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL done_no_pending: got done=1 expected no result (cycle %0d)", cyc);
               end else begin
                  held = exp_q.pop_front();
               end
            end
            chk("result", 32'({D, borrow_out, overflow, zero}), 32'(held));
         end
      end
   end

   // One accepted operation: start high for one edge, operands scrambled afterwards.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin);
      @(negedge Clk);
      A = a; B = b; borrow_in = bin; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      A = WIDTH'($urandom); B = WIDTH'($urandom); borrow_in = 1'($urandom);
      repeat (N + 1) @(negedge Clk);
   endtask

   function automatic logic [WIDTH-1:0] pick();
      case ($urandom_range(0, 5))
         0: pick = '0;
         1: pick = '1;
         2: pick = 16'h8000;
         3: pick = 16'h7FFF;
         default: pick = WIDTH'($urandom);
      endcase
   endfunction

   initial begin
      Reset = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_done", 32'(done), 32'(0));
      chk("reset_out", 32'({D, borrow_out, overflow, zero}), 32'(0));
      Reset = 1'b0;
      @(negedge Clk);

      // Directed cases
      do_op(16'h1234, 16'h0234, 1'b0);
      do_op(16'h0000, 16'h0001, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b0);
      do_op(16'h7FFF, 16'hFFFF, 1'b0);
      do_op(16'h5555, 16'h5555, 1'b0);
      do_op(16'h5555, 16'h5555, 1'b1);
      do_op(16'h8000, 16'h0000, 1'b1);

      // Random starts at random times, including while busy (must be ignored)
      for (int i = 0; i < 200; i++) begin
         @(negedge Clk);
         start = ($urandom_range(0, 2) == 0);
         A = pick(); B = pick(); borrow_in = 1'($urandom);
      end
      @(negedge Clk);
      start = 1'b0;
      repeat (N + 2) @(negedge Clk);

      // start held high, operands changing every cycle
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         A = pick(); B = pick(); borrow_in = 1'($urandom);
         @(negedge Clk);
      end
      start = 1'b0;
      repeat (N + 2) @(negedge Clk);

      // Reset in the middle of an operation
      do_op(16'h1234, 16'h0234, 1'b0);
      @(negedge Clk);
      A = 16'hFFFF; B = 16'h0001; borrow_in = 1'b0; start = 1'b1;
      @(negedge Clk);                 // after E0
      start = 1'b0;
      repeat (2) @(negedge Clk);      // after E2
      Reset = 1'b1;
      #1;
      chk("midreset_busy", 32'(busy), 32'(0));
      chk("midreset_done", 32'(done), 32'(0));
      chk("midreset_out", 32'({D, borrow_out, overflow, zero}), 32'(0));
      @(negedge Clk);
      Reset = 1'b0;
      do_op(16'h0003, 16'h0001, 1'b0);
      do_op(16'hA5A5, 16'h5A5A, 1'b1);

      // Drain with a bounded wait
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge Clk);
      chk("drain", 32'(exp_q.size()), 32'(0));
      repeat (2) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
